// File: rtl/playback_pkg.sv
// playback_pkg: shared sizes, slice type and FSM states for the playback path.
package playback_pkg;
    localparam int NUM_CH = 32;
    localparam int SLICE = 8;
    localparam int LEN_W = 24;
    localparam int PHASE_W = $clog2(SLICE);
    typedef logic [NUM_CH-1:0][SLICE-1:0] slice_t;
    typedef enum logic [1:0] {IDLE, PRIME, RUN} pb_state_t;
endpackage

// File: rtl/slice_serializer.sv
// slice_serializer: one-slice holding register feeding a per-lane MSB-first shift register.
module slice_serializer
    import playback_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                accept,
    input  logic                flush,
    input  slice_t              in_slice,
    output logic                full,
    output logic [PHASE_W-1:0]  phase,
    output logic [NUM_CH-1:0]   next_bits
);
    slice_t holding, shift;
    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= 1'b0;
            phase <= '0;
            holding <= '0;
            shift <= '0;
        end else begin
            full <= !flush && (accept || (full && !load));
            if (accept)
                holding <= in_slice;
            if (flush)
                phase <= '0;
            else if (load)
                phase <= PHASE_W'(1);
            else if (step)
                phase <= (phase == PHASE_W'(SLICE - 1)) ? '0 : phase + 1'b1;
            for (int i = 0; i < NUM_CH; i++)
                if (load)
                    shift[i] <= holding[i] << 1;
                else if (step)
                    shift[i] <= shift[i] << 1;
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_bits
        assign next_bits[i] = load ? holding[i][SLICE-1] : shift[i][SLICE-1];
    end
endmodule

// File: rtl/playback_backend.sv
// playback_backend: serialises slices onto NUM_CH pins, one sample per clk.
// Define PLAYBACK_CNT_EN to add the slices_sent counter output.
module playback_backend
    import playback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  length,
    input  logic [NUM_CH-1:0] idle_level,
    input  logic              in_valid,
    output logic              in_ready,
    input  slice_t            in_slice,
    output logic [NUM_CH-1:0] channels,
    output logic              busy,
    output logic              done,
`ifdef PLAYBACK_CNT_EN
    output logic [LEN_W-1:0]  slices_sent,
`endif
    output logic              underflow
);
    pb_state_t state, state_nx;
    logic [LEN_W-1:0] remaining;
    logic [PHASE_W-1:0] phase;
    logic [NUM_CH-1:0] next_bits;
    logic full, accept, go, boundary, load, step, starve, flush;
    assign busy = state != IDLE;
    assign in_ready = busy && !full;
    assign accept = in_valid && in_ready;
    // phase wraps to 0 while bit 0 is on the pins, so that edge is the slice boundary
    always_comb begin
        go = state == IDLE && start && !stop && length != '0;
        boundary = state == RUN && phase == '0;
        load = !stop && full && (state == PRIME || (boundary && remaining != '0));
        step = !stop && state == RUN && !boundary;
        starve = !stop && boundary && remaining != '0 && !full;
        state_nx = state;
        if (go)
            state_nx = PRIME;
        else if (busy && (stop || (boundary && !load)))
            state_nx = IDLE;
        else if (load)
            state_nx = RUN;
        flush = busy && state_nx == IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            channels <= idle_level;
            done <= 1'b0;
            underflow <= 1'b0;
            remaining <= '0;
        end else begin
            state <= state_nx;
            channels <= (state_nx == IDLE) ? idle_level : (load || step) ? next_bits : channels;
            done <= flush || (state == IDLE && start && !stop && length == '0);
            underflow <= !go && (underflow || starve);
            remaining <= go ? length : load ? remaining - 1'b1 : remaining;
        end
    end
`ifdef PLAYBACK_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            slices_sent <= '0;
        else
            slices_sent <= go ? '0 : load ? slices_sent + 1'b1 : slices_sent;
    end
`endif
    slice_serializer u_ser (
        .clk(clk),
        .rst(rst),
        .load(load),
        .step(step),
        .accept(accept),
        .flush(flush),
        .in_slice(in_slice),
        .full(full),
        .phase(phase),
        .next_bits(next_bits)
    );
endmodule
